axi_word_packer: RTL and testbench

//  Parametrised successor to the fixed 8->128 packer between sync FIFO and AXI write master.

---
 rtl/axi_word_packer.sv | 142 ++++++++++++++
 tb/tb_axi_word_packer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi_word_packer.sv
// ============================================================================
// Module   : axi_word_packer
// Purpose  : Packs IN_WIDTH beats into OUT_WIDTH words with valid/ready on both
//            sides, explicit flush of partial words and a per-lane strobe.
//            Optional idle-timeout flush enabled by PACKER_TIMEOUT_FLUSH_EN.
// Revision : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

module axi_word_packer #(
    parameter int IN_WIDTH       = 8,
    parameter int OUT_WIDTH      = 128,
    parameter int MSB_FIRST      = 0,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [IN_WIDTH-1:0]            in_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           flush,
    output logic [OUT_WIDTH-1:0]           out_data,
    output logic [OUT_WIDTH/IN_WIDTH-1:0]  out_strb,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [15:0]                    word_cnt
);

    localparam int LANES = OUT_WIDTH / IN_WIDTH;
    localparam int CW    = $clog2(LANES + 1);

    localparam logic [0:0]    c_fill      = 1'b0;
    localparam logic [0:0]    c_hold      = 1'b1;
    localparam logic [CW-1:0] c_last_lane = CW'(LANES - 1);

    logic [0:0]           r_state;
    logic [CW-1:0]        r_cnt;
    logic [OUT_WIDTH-1:0] r_data;
    logic [LANES-1:0]     r_strb;
    logic [15:0]          r_word_cnt;

    logic [0:0]           w_state_nxt;
    logic [CW-1:0]        w_cnt_nxt;
    logic [OUT_WIDTH-1:0] w_data_nxt;
    logic [LANES-1:0]     w_strb_nxt;
    logic [15:0]          w_word_cnt_nxt;
    logic                 w_accept;
    logic                 w_timeout;
    logic [CW-1:0]        w_lane;

    assign w_accept = in_valid && (r_state == c_fill);
    assign w_lane   = (MSB_FIRST != 0) ? (c_last_lane - r_cnt) : r_cnt;

`ifdef PACKER_TIMEOUT_FLUSH_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] r_timer;

    // An accept restarts the idle count; the cycle after it is idle cycle one,
    // so the partial word goes valid exactly TIMEOUT_CYCLES after the accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer <= '0;
        end else if (w_accept) begin
            r_timer <= TW'(1);
        end else if ((r_state == c_hold) || (r_cnt == '0)) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + TW'(1);
        end
    end

    assign w_timeout = (r_state == c_fill) && (r_cnt != '0) &&
                       (r_timer == TW'(TIMEOUT_CYCLES - 1));
`else
    // No timer in this build; the expression is constant false for any legal value.
    assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_data_nxt     = r_data;
        w_strb_nxt     = r_strb;
        w_word_cnt_nxt = r_word_cnt;
        case (r_state)
            c_fill: begin
                if (w_accept) begin
                    w_cnt_nxt = r_cnt + CW'(1);
                    for (int k = 0; k < LANES; k++) begin
                        if (w_lane == CW'(k)) begin
                            w_data_nxt[k*IN_WIDTH +: IN_WIDTH] = in_data;
                            w_strb_nxt[k]                      = 1'b1;
                        end
                    end
                end
                // A flush only emits when at least one lane (old or just accepted) holds data.
                if ((w_accept && (r_cnt == c_last_lane)) ||
                    ((flush || w_timeout) && ((r_cnt != '0) || w_accept))) begin
                    w_state_nxt = c_hold;
                end
            end
            c_hold: begin
                if (out_ready) begin
                    w_state_nxt    = c_fill;
                    w_cnt_nxt      = '0;
                    w_data_nxt     = '0;
                    w_strb_nxt     = '0;
                    w_word_cnt_nxt = r_word_cnt + 16'd1;
                end
            end
            default: begin
                w_state_nxt = c_fill;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_fill;
            r_cnt      <= '0;
            r_data     <= '0;
            r_strb     <= '0;
            r_word_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_data     <= w_data_nxt;
            r_strb     <= w_strb_nxt;
            r_word_cnt <= w_word_cnt_nxt;
        end
    end

    assign in_ready  = (r_state == c_fill) && !rst;
    assign out_valid = (r_state == c_hold);
    assign out_data  = r_data;
    assign out_strb  = r_strb;
    assign word_cnt  = r_word_cnt;

endmodule

`default_nettype wire

// File: tb/tb_axi_word_packer.sv
// ============================================================================
// Module   : tb_axi_word_packer
// Purpose  : Self-checking bench for axi_word_packer (LSB- and MSB-first
//            instances side by side) against a queue-based word model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi_word_packer;

    localparam int c_TO = 100;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [7:0]   in_data = '0;
    logic         in_valid = 1'b0;
    logic         flush = 1'b0;
    logic         out_ready = 1'b0;

    logic         l_in_ready, m_in_ready, l_out_valid, m_out_valid;
    logic [127:0] l_out_data, m_out_data;
    logic [15:0]  l_out_strb, m_out_strb, l_word_cnt, m_word_cnt;

    always #5 clk = ~clk;

    axi_word_packer #(.IN_WIDTH(8), .OUT_WIDTH(128), .MSB_FIRST(0), .TIMEOUT_CYCLES(c_TO)) dut_l (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(l_in_ready),
        .flush(flush), .out_data(l_out_data), .out_strb(l_out_strb), .out_valid(l_out_valid),
        .out_ready(out_ready), .word_cnt(l_word_cnt));

    axi_word_packer #(.IN_WIDTH(8), .OUT_WIDTH(128), .MSB_FIRST(1), .TIMEOUT_CYCLES(c_TO)) dut_m (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(m_in_ready),
        .flush(flush), .out_data(m_out_data), .out_strb(m_out_strb), .out_valid(m_out_valid),
        .out_ready(out_ready), .word_cnt(m_word_cnt));

    // Reference model: beats collected in a queue, emitted as a word on fill or flush.
    logic [7:0]   mq[$];
    bit           m_hold;
    logic [127:0] m_data_l, m_data_m;
    logic [15:0]  m_strb_l, m_strb_m, m_wc;
    int           cyc, m_last;
    int           n_tests, n_fail;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_pack();
        m_data_l = '0; m_data_m = '0; m_strb_l = '0; m_strb_m = '0;
        for (int i = 0; i < mq.size(); i++) begin
            m_data_l[i*8 +: 8]      = mq[i];
            m_strb_l[i]             = 1'b1;
            m_data_m[(15-i)*8 +: 8] = mq[i];
            m_strb_m[15-i]          = 1'b1;
        end
    endtask

    task automatic tick(input bit v, input logic [7:0] d, input bit f, input bit o, input bit r);
        bit to;
        to = 1'b0;
        in_valid = v; in_data = d; flush = f; out_ready = o; rst = r;
        @(negedge clk);
        chk("in_ready_l", l_in_ready, !m_hold && !r);
        chk("in_ready_m", m_in_ready, !m_hold && !r);
        @(posedge clk);
        if (r) begin
            mq.delete(); m_hold = 1'b0; m_wc = '0;
            m_data_l = '0; m_data_m = '0; m_strb_l = '0; m_strb_m = '0;
        end else if (m_hold) begin
            if (o) begin
                m_hold = 1'b0;
                m_wc   = m_wc + 16'd1;
            end
        end else begin
`ifdef PACKER_TIMEOUT_FLUSH_EN
            to = (mq.size() > 0) && (cyc - m_last == c_TO - 1);
`endif
            if (v) begin
                mq.push_back(d);
                m_last = cyc;
            end
            if (mq.size() == 16 || ((f || to) && mq.size() > 0)) begin
                model_pack();
                m_hold = 1'b1;
                mq.delete();
            end
        end
        cyc++;
        #1;
        chk("out_valid_l", l_out_valid, m_hold);
        chk("out_valid_m", m_out_valid, m_hold);
        if (m_hold) begin
            chk("out_data_l", l_out_data, m_data_l);
            chk("out_strb_l", l_out_strb, m_strb_l);
            chk("out_data_m", m_out_data, m_data_m);
            chk("out_strb_m", m_out_strb, m_strb_m);
        end
        chk("word_cnt_l", l_word_cnt, m_wc);
        chk("word_cnt_m", m_word_cnt, m_wc);
    endtask

    typedef struct {
        bit          v;
        logic [7:0]  d;
        bit          f;
        bit          o;
        bit          e_valid;
        logic [31:0] e_lo;
        logic [15:0] e_strb;
        logic [15:0] e_wc;
    } vec_t;

    vec_t tbl[14];

    initial begin
        int  acc, first;
        bit  seen;
        n_tests = 0; n_fail = 0; cyc = 0; m_last = 0; m_hold = 1'b0; m_wc = '0;

        tbl = '{
            '{1'b1, 8'hC0, 1'b0, 1'b0, 1'b0, 32'h0,        16'h0000, 16'd0},
            '{1'b1, 8'hC1, 1'b0, 1'b0, 1'b0, 32'h0,        16'h0000, 16'd0},
            '{1'b1, 8'hC2, 1'b1, 1'b0, 1'b1, 32'h00C2C1C0, 16'h0007, 16'd0},
            '{1'b1, 8'hD0, 1'b0, 1'b0, 1'b1, 32'h00C2C1C0, 16'h0007, 16'd0},
            '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0,        16'h0000, 16'd1},
            '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 32'h0,        16'h0000, 16'd1},
            '{1'b1, 8'hE0, 1'b0, 1'b0, 1'b0, 32'h0,        16'h0000, 16'd1},
            '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 32'h000000E0, 16'h0001, 16'd1},
            '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0,        16'h0000, 16'd2},
            '{1'b1, 8'hC0, 1'b0, 1'b0, 1'b0, 32'h0,        16'h0000, 16'd2},
            '{1'b1, 8'hC1, 1'b0, 1'b0, 1'b0, 32'h0,        16'h0000, 16'd2},
            '{1'b1, 8'hC2, 1'b0, 1'b0, 1'b0, 32'h0,        16'h0000, 16'd2},
            '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 32'h00C2C1C0, 16'h0007, 16'd2},
            '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0,        16'h0000, 16'd3}
        };

        // Reset state
        tick(0, 8'h00, 0, 0, 1);
        chk("rst_valid", l_out_valid, 1'b0);
        chk("rst_data", l_out_data, 128'h0);
        chk("rst_strb", l_out_strb, 16'h0);
        chk("rst_wcnt", l_word_cnt, 16'h0);
        tick(0, 8'h00, 0, 0, 0);

        // Table of flush corner cases
        tick(0, 8'h00, 0, 0, 1);
        for (int i = 0; i < 14; i++) begin
            tick(tbl[i].v, tbl[i].d, tbl[i].f, tbl[i].o, 0);
            chk($sformatf("tbl%0d_valid", i), l_out_valid, tbl[i].e_valid);
            if (tbl[i].e_valid) begin
                chk($sformatf("tbl%0d_data", i), l_out_data, {96'h0, tbl[i].e_lo});
                chk($sformatf("tbl%0d_strb", i), l_out_strb, tbl[i].e_strb);
            end
            chk($sformatf("tbl%0d_wcnt", i), l_word_cnt, tbl[i].e_wc);
        end

        // Full word A0..AF in both lane orders
        tick(0, 8'h00, 0, 0, 1);
        for (int i = 0; i < 16; i++) tick(1, 8'hA0 + 8'(i), 0, 1, 0);
        chk("full_data_l", l_out_data, 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0);
        chk("full_strb_l", l_out_strb, 16'hFFFF);
        chk("full_data_m", m_out_data, 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF);
        tick(0, 8'h00, 0, 1, 0);
        chk("full_wcnt", l_word_cnt, 16'd1);

        // Output backpressure: F0 stalls, then lands in lane 0 of the next word
        tick(0, 8'h00, 0, 0, 1);
        for (int i = 0; i < 16; i++) tick(1, 8'hC0 + 8'(i), 0, 0, 0);
        for (int i = 0; i < 50; i++) tick(1, 8'hF0, 0, 0, 0);
        chk("bp_data", l_out_data, 128'hCFCECDCCCBCAC9C8C7C6C5C4C3C2C1C0);
        chk("bp_ready", l_in_ready, 1'b0);
        tick(1, 8'hF0, 0, 1, 0);
        tick(1, 8'hF0, 0, 0, 0);
        tick(0, 8'h00, 1, 0, 0);
        chk("bp_next_data", l_out_data, 128'h0F0);
        chk("bp_next_strb", l_out_strb, 16'h0001);
        tick(0, 8'h00, 0, 1, 0);

        // Reset mid-word discards the partial word
        tick(0, 8'h00, 0, 0, 1);
        for (int i = 0; i < 7; i++) tick(1, 8'h10 + 8'(i), 0, 1, 0);
        tick(0, 8'h00, 0, 1, 1);
        for (int i = 0; i < 16; i++) tick(1, 8'hF0 + 8'(i), 0, 1, 0);
        chk("rstmid_data", l_out_data, 128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0);
        chk("rstmid_strb", l_out_strb, 16'hFFFF);
        tick(0, 8'h00, 0, 1, 0);
        chk("rstmid_wcnt", l_word_cnt, 16'd1);

        // Idle after a partial word: timeout flush or wait for an explicit flush
        tick(0, 8'h00, 0, 0, 1);
        for (int i = 0; i < 5; i++) tick(1, 8'h50 + 8'(i), 0, 0, 0);
        acc = cyc - 1; seen = 1'b0; first = 0;
        for (int i = 0; i < 150 && !seen; i++) begin
            tick(0, 8'h00, 0, 0, 0);
            if (l_out_valid) begin
                seen = 1'b1;
                first = cyc - acc;
            end
        end
`ifdef PACKER_TIMEOUT_FLUSH_EN
        chk("timeout_seen", seen, 1'b1);
        chk("timeout_lat", first, c_TO);
`else
        chk("no_timeout", seen, 1'b0);
        tick(0, 8'h00, 1, 0, 0);
`endif
        chk("idle_strb", l_out_strb, 16'h001F);
        tick(0, 8'h00, 0, 1, 0);

        // MSB-first partial word
        tick(0, 8'h00, 0, 0, 1);
        tick(1, 8'hA0, 0, 0, 0);
        tick(1, 8'hA1, 0, 0, 0);
        tick(0, 8'h00, 1, 0, 0);
        chk("msb_strb", m_out_strb, 16'hC000);
        chk("msb_data", m_out_data, {8'hA0, 8'hA1, 112'h0});
        tick(0, 8'h00, 0, 1, 0);

        // Random traffic against the model
        tick(0, 8'h00, 0, 0, 1);
        for (int i = 0; i < 800; i++) begin
            tick(($urandom % 4) != 0, 8'($urandom), ($urandom % 12) == 0,
                 ($urandom % 3) != 0, ($urandom % 250) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
